lstm_seq_ctrl: RTL and testbench
================================

// Module: lstm_seq_ctrl
// PURPOSE
// Sequencer for the lstm_top cell. Accepts a sequence of 1..MAX_STEPS input vectors over a valid/ready stream.
// Fires one cell evaluation per vector and feeds each hidden-state result back as y_in for the next step.
// Streams every step's hidden state out and flags sequence completion or a cell timeout.
// Sits between the input buffer/DMA and lstm_top; replaces bench-driven start/feedback sequencing.
// PARAMETERS
// DATA_WIDTH   8   signed width of one vector lane
// VEC_LEN      4   lanes per vector; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]
// MAX_STEPS    8   longest sequence; seq_len above this is clamped to MAX_STEPS
// START_CYC    2   cycles core_start is held high per evaluation (>=1)
// TIMEOUT      63  max cycles in RUN awaiting core_finished before abort
// PORTS
// clk            in   1              clock, rising edge
// rst_n          in   1              synchronous active-low reset
// seq_start      in   1              pulse: begin a sequence; honoured only in IDLE
// seq_len        in   4              step count, sampled with seq_start
// in_valid       in   1              input vector valid
// in_ready       out  1              controller accepts a vector (WAIT_X only)
// in_data        in   VEC_LEN*DW     input vector x_t
// core_start     out  1              start to lstm_top
// core_x         out  VEC_LEN*DW     x to lstm_top, held stable in FIRE/RUN
// core_y_in      out  VEC_LEN*DW     previous hidden state to lstm_top, held stable in FIRE/RUN
// core_finished  in   1              lstm_top done
// core_y_out     in   VEC_LEN*DW     lstm_top hidden-state result
// h_valid        out  1              one-cycle pulse: h_data holds a new hidden state
// h_data         out  VEC_LEN*DW     current hidden-state register
// step_idx       out  4              index of the step in progress / last completed
// busy           out  1              high in every state except IDLE
// seq_done       out  1              one-cycle pulse: all steps completed
// timeout_err    out  1              one-cycle pulse: sequence aborted on timeout
// BEHAVIOUR
// Reset: state=IDLE; all outputs, x_reg, h_reg, step, len and timer = 0. Applies mid-sequence; core_start is low the cycle after the reset edge.
// IDLE:
//   seq_start && seq_len!=0: len<=min(seq_len,MAX_STEPS); h_reg<=0; step<=0 -> WAIT_X.
//   seq_start && seq_len==0: seq_done pulses next cycle; stay IDLE.
// WAIT_X: in_ready=1 (combinational from state). in_valid&&in_ready: x_reg<=in_data -> FIRE. No timeout here.
// FIRE: core_start=1 for exactly START_CYC cycles (registered, first high cycle follows the accept edge) -> RUN with timer<=0.
// RUN: core_start=0; timer++ each cycle.
//   core_finished=1: h_reg<=core_y_out; h_valid=1 next cycle with h_data=new h_reg.
//     If step==len-1 -> DONE; else step++ -> WAIT_X.
//   timer==TIMEOUT with no finish -> ERR. core_finished wins if both occur in the same cycle.
// DONE: seq_done=1 for one cycle -> IDLE. h_data keeps the final state until the next seq_start.
// ERR: timeout_err=1 for one cycle -> IDLE. h_reg is not updated.
// core_finished outside RUN is ignored. seq_start while busy is ignored.
// core_x=x_reg and core_y_in=h_reg at all times. step_idx=step.
// No arithmetic on data; vectors pass bit-exact. Step/timer counters saturate and never wrap.
// Per-step overhead: 1 cycle input accept + START_CYC + core latency + 1 cycle capture.
// TESTING (bench core model: fixed 10-cycle latency, y_out lane = x + y_in mod 256)
// 1) Reset, seq_len=1, x={25,35,F5,EB}h -> core_y_in=0; single h_valid with h={25,35,F5,EB}; seq_done 1 cycle later; busy low.
// 2) seq_len=2, x1 as in 1), x2={2D,BC,29,57}h -> second core_y_in={25,35,F5,EB}; h={52,F1,1E,42}h; step_idx 0 then 1.
// 3) seq_len=5 with in_valid stalled 7 cycles before step 3 -> in_ready held, core_start stays low, no h_valid until accept, all 5 results correct.
// 4) Model never asserts finished -> timeout_err pulses exactly TIMEOUT+1 cycles after RUN entry; IDLE next cycle; h_data unchanged.
// 5) seq_len=0 -> seq_done pulse only, no core_start. seq_len=12 -> exactly 8 steps run.
// 6) rst_n low 1 cycle during RUN of step 2 -> all outputs 0; a new seq_start then runs cleanly from h=0; a stray core_finished in IDLE is ignored.

Source files
------------

// File: rtl/lstm_seq_ctrl_if.sv
// Input-vector stream and lstm_top core bus seen by the sequencer.
// master = sequencer side; slave = input buffer plus lstm_top side.
interface lstm_seq_ctrl_if #(
   parameter int DATA_WIDTH = 8,
   parameter int VEC_LEN    = 4
) ();
   localparam int VW = DATA_WIDTH * VEC_LEN;

   logic          in_valid;
   logic          in_ready;
   logic [VW-1:0] in_data;
   logic          core_start;
   logic [VW-1:0] core_x;
   logic [VW-1:0] core_y_in;
   logic          core_finished;
   logic [VW-1:0] core_y_out;

   modport master (
      input  in_valid, in_data, core_finished, core_y_out,
      output in_ready, core_start, core_x, core_y_in
   );

   modport slave (
      output in_valid, in_data, core_finished, core_y_out,
      input  in_ready, core_start, core_x, core_y_in
   );
endinterface

// File: rtl/lstm_seq_ctrl.sv
// Sequencer for lstm_top: one cell evaluation per input vector, hidden state fed back
// as y_in for the next step, each step's hidden state streamed out.
module lstm_seq_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int VEC_LEN    = 4,
   parameter int MAX_STEPS  = 8,
   parameter int START_CYC  = 2,
   parameter int TIMEOUT    = 63
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          seq_start,
   input  logic [3:0]                    seq_len,
   lstm_seq_ctrl_if.master               bus,
   output logic                          h_valid,
   output logic [VEC_LEN*DATA_WIDTH-1:0] h_data,
   output logic [3:0]                    step_idx,
   output logic                          busy,
   output logic                          seq_done,
   output logic                          timeout_err
);
   localparam int VW = VEC_LEN * DATA_WIDTH;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int FW = (START_CYC > 1) ? $clog2(START_CYC) : 1;
   localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT);
   localparam logic [FW-1:0] FIRE_LAST = FW'(START_CYC - 1);
   localparam logic [3:0]    STEPS_MAX = 4'(MAX_STEPS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_X,
      S_FIRE,
      S_RUN,
      S_DONE,
      S_ERR
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [VW-1:0] r_x;
   logic [VW-1:0] r_h;
   logic [3:0]    r_step;
   logic [3:0]    r_len;
   logic [TW-1:0] r_timer;
   logic [FW-1:0] r_fire_cnt;
   logic          r_core_start;
   logic          r_h_valid;
   logic          r_seq_done;
   logic          r_timeout_err;

   logic          w_start_ok;
   logic          w_start_empty;
   logic          w_accept;
   logic          w_finish;
   logic          w_last_step;
   logic [3:0]    w_len_clamped;

   assign w_start_ok    = seq_start && (seq_len != 4'd0);
   assign w_start_empty = seq_start && (seq_len == 4'd0);
   assign w_accept      = (r_state == S_WAIT_X) && bus.in_valid;
   assign w_finish      = (r_state == S_RUN) && bus.core_finished;
   assign w_last_step   = (r_step == r_len - 4'd1);
   assign w_len_clamped = (seq_len > STEPS_MAX) ? STEPS_MAX : seq_len;

   always_comb begin
      // NOTE: next state defaults to the current state so no path through the case infers a latch.
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_start_ok) w_state_nxt = S_WAIT_X;
         S_WAIT_X: if (bus.in_valid) w_state_nxt = S_FIRE;
         S_FIRE:   if (r_fire_cnt == FIRE_LAST) w_state_nxt = S_RUN;
         S_RUN: begin
            // A finish arriving on the timeout cycle still counts as a completed step.
            if (bus.core_finished)      w_state_nxt = w_last_step ? S_DONE : S_WAIT_X;
            else if (r_timer == TIMER_MAX) w_state_nxt = S_ERR;
         end
         S_DONE:   w_state_nxt = S_IDLE;
         S_ERR:    w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: all state here uses non-blocking assignment so every register samples pre-edge values.
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_x           <= '0;
         r_h           <= '0;
         r_step        <= '0;
         r_len         <= '0;
         r_timer       <= '0;
         r_fire_cnt    <= '0;
         r_core_start  <= 1'b0;
         r_h_valid     <= 1'b0;
         r_seq_done    <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_core_start  <= (w_state_nxt == S_FIRE);
         r_h_valid     <= w_finish;
         // seq_done trails the final h_valid by one cycle; timeout_err marks the ERR cycle itself.
         r_seq_done    <= (r_state == S_DONE) || ((r_state == S_IDLE) && w_start_empty);
         r_timeout_err <= (w_state_nxt == S_ERR);

         case (r_state)
            S_IDLE: begin
               if (w_start_ok) begin
                  r_len  <= w_len_clamped;
                  r_h    <= '0;
                  r_step <= '0;
               end
            end
            S_WAIT_X: begin
               if (w_accept) begin
                  r_x        <= bus.in_data;
                  r_fire_cnt <= '0;
               end
            end
            S_FIRE: begin
               r_timer <= '0;
               if (r_fire_cnt != FIRE_LAST) r_fire_cnt <= r_fire_cnt + FW'(1);
            end
            S_RUN: begin
               if (r_timer != TIMER_MAX) r_timer <= r_timer + TW'(1);
               if (bus.core_finished) begin
                  r_h <= bus.core_y_out;
                  if (!w_last_step && (r_step != 4'hF)) r_step <= r_step + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready   = (r_state == S_WAIT_X);
   assign bus.core_start = r_core_start;
   assign bus.core_x     = r_x;
   assign bus.core_y_in  = r_h;
   assign h_valid        = r_h_valid;
   assign h_data         = r_h;
   assign step_idx       = r_step;
   assign busy           = (r_state != S_IDLE);
   assign seq_done       = r_seq_done;
   assign timeout_err    = r_timeout_err;
endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// Directed bench for lstm_seq_ctrl with a fixed-latency lstm_top stand-in
// (10 cycles from core_start, each lane y_out = x + y_in mod 256).
module tb_lstm_seq_ctrl;
   localparam int DW       = 8;
   localparam int VL       = 4;
   localparam int VW       = DW * VL;
   localparam int TIMEOUT  = 63;
   localparam int CORE_LAT = 10;

   localparam logic [VW-1:0] X1 = 32'h2535F5EB;
   localparam logic [VW-1:0] X2 = 32'h2DBC2957;
   localparam logic [VW-1:0] H2 = 32'h52F11E42;
   localparam logic [VW-1:0] H5 = 32'h91A43549;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          seq_start;
   logic [3:0]    seq_len;
   logic          h_valid;
   logic [VW-1:0] h_data;
   logic [3:0]    step_idx;
   logic          busy;
   logic          seq_done;
   logic          timeout_err;

   lstm_seq_ctrl_if #(.DATA_WIDTH(DW), .VEC_LEN(VL)) bus ();

   lstm_seq_ctrl #(
      .DATA_WIDTH(DW), .VEC_LEN(VL), .MAX_STEPS(8), .START_CYC(2), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .seq_start   (seq_start),
      .seq_len     (seq_len),
      .bus         (bus.master),
      .h_valid     (h_valid),
      .h_data      (h_data),
      .step_idx    (step_idx),
      .busy        (busy),
      .seq_done    (seq_done),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   function automatic logic [VW-1:0] lane_add(input logic [VW-1:0] a, input logic [VW-1:0] b);
      logic [VW-1:0] r;
      r = '0;
      for (int i = 0; i < VL; i++) r[i*DW +: DW] = a[i*DW +: DW] + b[i*DW +: DW];
      return r;
   endfunction

   // lstm_top stand-in
   logic          model_en;
   logic          model_fin;
   logic          stray_fin;
   logic [VW-1:0] model_y;
   logic          m_busy;
   int            m_cnt;
   logic [VW-1:0] m_x;
   logic [VW-1:0] m_y;
   logic          m_prev;

   always @(posedge clk) begin
      model_fin <= 1'b0;
      m_prev    <= bus.core_start;
      if (!rst_n || !model_en) begin
         m_busy <= 1'b0;
         m_cnt  <= 0;
         if (!rst_n) model_y <= '0;
      end else if (m_busy) begin
         if (m_cnt == CORE_LAT - 1) begin
            model_fin <= 1'b1;
            model_y   <= lane_add(m_x, m_y);
            m_busy    <= 1'b0;
         end else begin
            m_cnt <= m_cnt + 1;
         end
      end else if (bus.core_start && !m_prev) begin
         m_busy <= 1'b1;
         m_cnt  <= 1;
         m_x    <= bus.core_x;
         m_y    <= bus.core_y_in;
      end
   end

   assign bus.core_finished = model_fin | stray_fin;
   assign bus.core_y_out    = model_y;

   int n_vec = 0;
   int n_mis = 0;

   // Results of the last run_seq call.
   logic [VW-1:0] vec     [12];
   logic [VW-1:0] ev_h    [16];
   int            ev_h_cyc[16];
   logic [VW-1:0] ev_cx   [16];
   logic [VW-1:0] ev_cy   [16];
   logic [3:0]    ev_step [16];
   int            n_h, n_st, n_done, n_terr;
   int            done_cyc, terr_cyc, run_entry_cyc, stall_cnt;
   logic          busy_at_done, busy_at_terr;
   bit            stall_viol, seq_ended;

   // Runs one sequence: feeds vec[] whenever in_ready, optionally withholding vector
   // stall_idx for stall_cyc ready cycles, and disabling the core after kill_after results.
   task automatic run_seq(input logic [3:0] len_req, input int stall_idx, input int stall_cyc,
                          input int kill_after, input int budget);
      int   k;
      logic prev_cs;
      n_h = 0; n_st = 0; n_done = 0; n_terr = 0;
      done_cyc = -1; terr_cyc = -1; run_entry_cyc = -1; stall_cnt = 0;
      stall_viol = 0; seq_ended = 0; k = 0; prev_cs = 1'b0;
      seq_start = 1'b1;
      seq_len   = len_req;
      for (int cyc = 1; cyc <= budget && !seq_ended; cyc++) begin
         @(negedge clk);
         seq_start = 1'b0;
         if (bus.core_start && !prev_cs && n_st < 16) begin
            ev_cx[n_st]   = bus.core_x;
            ev_cy[n_st]   = bus.core_y_in;
            ev_step[n_st] = step_idx;
            n_st++;
         end
         if (!bus.core_start && prev_cs) run_entry_cyc = cyc;
         prev_cs = bus.core_start;
         if (h_valid && n_h < 16) begin
            ev_h[n_h]     = h_data;
            ev_h_cyc[n_h] = cyc;
            n_h++;
            if (n_h == kill_after) model_en = 1'b0;
         end
         if (seq_done) begin
            n_done++; done_cyc = cyc; busy_at_done = busy; seq_ended = 1;
         end
         if (timeout_err) begin
            n_terr++; terr_cyc = cyc; busy_at_terr = busy; seq_ended = 1;
         end
         if (bus.in_ready && k < 12) begin
            if (k == stall_idx && stall_cnt < stall_cyc) begin
               stall_cnt++;
               if (bus.core_start || (stall_cnt > 1 && h_valid)) stall_viol = 1;
               bus.in_valid = 1'b0;
            end else begin
               bus.in_valid = 1'b1;
               bus.in_data  = vec[k];
               k++;
            end
         end else begin
            if (k == stall_idx && stall_cnt > 0) stall_viol = 1;
            bus.in_valid = 1'b0;
         end
      end
      bus.in_valid = 1'b0;
      n_vec++;
      if (!seq_ended) begin
         n_mis++;
         $display("FAIL seq_end: no seq_done/timeout_err within %0d cycles (len %0d)", budget, len_req);
      end
   endtask

   task automatic wait_for(input int which, input int budget, input string what);
      bit hit;
      hit = 0;
      for (int i = 0; i < budget && !hit; i++) begin
         @(negedge clk);
         case (which)
            0:       hit = bus.in_ready;
            1:       hit = h_valid;
            2:       hit = bus.core_start;
            default: hit = !bus.core_start;
         endcase
      end
      n_vec++;
      if (!hit) begin
         n_mis++;
         $display("FAIL wait_%s: not seen within %0d cycles", what, budget);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; seq_start = 1'b0; seq_len = 4'd0;
      bus.in_valid = 1'b0; bus.in_data = '0; stray_fin = 1'b0; model_en = 1'b1;
      repeat (3) @(negedge clk);
      n_vec++;
      if ({h_valid, busy, seq_done, timeout_err, bus.in_ready, bus.core_start} !== 6'b0) begin
         n_mis++;
         $display("FAIL reset_flags: got %b expected 000000",
                  {h_valid, busy, seq_done, timeout_err, bus.in_ready, bus.core_start});
      end
      n_vec++;
      if ({h_data, bus.core_x, bus.core_y_in, step_idx} !== '0) begin
         n_mis++;
         $display("FAIL reset_data: h %h x %h y_in %h step %0d expected all 0",
                  h_data, bus.core_x, bus.core_y_in, step_idx);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single_step();
      vec[0] = X1;
      run_seq(4'd1, -1, 0, 0, 200);
      n_vec++; if (n_st !== 1) begin n_mis++; $display("FAIL single_starts: got %0d expected 1", n_st); end
      n_vec++; if (ev_cy[0] !== '0) begin n_mis++; $display("FAIL single_y_in: got %h expected 0", ev_cy[0]); end
      n_vec++; if (ev_cx[0] !== X1) begin n_mis++; $display("FAIL single_x: got %h expected %h", ev_cx[0], X1); end
      n_vec++; if (n_h !== 1) begin n_mis++; $display("FAIL single_hcount: got %0d expected 1", n_h); end
      n_vec++; if (ev_h[0] !== X1) begin n_mis++; $display("FAIL single_h: got %h expected %h", ev_h[0], X1); end
      n_vec++;
      if (done_cyc !== ev_h_cyc[0] + 1) begin
         n_mis++;
         $display("FAIL single_done_lag: seq_done at %0d expected %0d", done_cyc, ev_h_cyc[0] + 1);
      end
      n_vec++; if (busy_at_done !== 1'b0) begin n_mis++; $display("FAIL single_busy: got %b expected 0", busy_at_done); end
   endtask

   task automatic test_two_steps();
      vec[0] = X1; vec[1] = X2;
      run_seq(4'd2, -1, 0, 0, 200);
      n_vec++; if (n_h !== 2) begin n_mis++; $display("FAIL two_hcount: got %0d expected 2", n_h); end
      n_vec++; if (ev_h[0] !== X1) begin n_mis++; $display("FAIL two_h0: got %h expected %h", ev_h[0], X1); end
      n_vec++; if (ev_cy[1] !== X1) begin n_mis++; $display("FAIL two_y_in1: got %h expected %h", ev_cy[1], X1); end
      n_vec++; if (ev_h[1] !== H2) begin n_mis++; $display("FAIL two_h1: got %h expected %h", ev_h[1], H2); end
      n_vec++;
      if ({ev_step[0], ev_step[1]} !== {4'd0, 4'd1}) begin
         n_mis++;
         $display("FAIL two_step_idx: got %0d,%0d expected 0,1", ev_step[0], ev_step[1]);
      end
      n_vec++; if (step_idx !== 4'd1) begin n_mis++; $display("FAIL two_step_end: got %0d expected 1", step_idx); end
   endtask

   task automatic test_stall();
      logic [VW-1:0] exp_h;
      vec[0] = 32'h01020304; vec[1] = 32'h10203040; vec[2] = 32'hF0E0D0C0;
      vec[3] = 32'h7F80FF01; vec[4] = 32'h11223344;
      run_seq(4'd5, 2, 7, 0, 400);
      n_vec++; if (stall_cnt !== 7) begin n_mis++; $display("FAIL stall_len: got %0d expected 7", stall_cnt); end
      n_vec++; if (stall_viol !== 1'b0) begin n_mis++; $display("FAIL stall_hold: got violation expected none"); end
      n_vec++; if (n_h !== 5) begin n_mis++; $display("FAIL stall_hcount: got %0d expected 5", n_h); end
      exp_h = '0;
      for (int i = 0; i < 5; i++) begin
         n_vec++;
         if (ev_cy[i] !== exp_h) begin
            n_mis++; $display("FAIL stall_y_in%0d: got %h expected %h", i, ev_cy[i], exp_h);
         end
         exp_h = lane_add(vec[i], exp_h);
         n_vec++;
         if (ev_h[i] !== exp_h) begin
            n_mis++; $display("FAIL stall_h%0d: got %h expected %h", i, ev_h[i], exp_h);
         end
      end
      n_vec++; if (ev_h[4] !== H5) begin n_mis++; $display("FAIL stall_final: got %h expected %h", ev_h[4], H5); end
   endtask

   task automatic test_timeout();
      vec[0] = X1; vec[1] = X2;
      run_seq(4'd2, -1, 0, 1, 300);
      n_vec++; if (n_terr !== 1 || n_done !== 0) begin
         n_mis++; $display("FAIL to_pulse: timeout_err %0d seq_done %0d expected 1,0", n_terr, n_done);
      end
      n_vec++;
      if (terr_cyc - run_entry_cyc !== TIMEOUT + 1) begin
         n_mis++;
         $display("FAIL to_latency: got %0d expected %0d", terr_cyc - run_entry_cyc, TIMEOUT + 1);
      end
      n_vec++; if (busy_at_terr !== 1'b1) begin n_mis++; $display("FAIL to_busy_err: got %b expected 1", busy_at_terr); end
      @(negedge clk);
      n_vec++;
      if ({busy, timeout_err} !== 2'b00) begin
         n_mis++; $display("FAIL to_idle: busy,timeout_err got %b expected 00", {busy, timeout_err});
      end
      n_vec++; if (h_data !== X1) begin n_mis++; $display("FAIL to_h_kept: got %h expected %h", h_data, X1); end
      model_en = 1'b1;
   endtask

   task automatic test_len_edges();
      logic [VW-1:0] exp_h;
      run_seq(4'd0, -1, 0, 0, 20);
      n_vec++; if (done_cyc !== 1) begin n_mis++; $display("FAIL len0_done: at cycle %0d expected 1", done_cyc); end
      n_vec++; if (n_st !== 0) begin n_mis++; $display("FAIL len0_starts: got %0d expected 0", n_st); end
      n_vec++; if (busy_at_done !== 1'b0) begin n_mis++; $display("FAIL len0_busy: got %b expected 0", busy_at_done); end

      exp_h = '0;
      for (int i = 0; i < 12; i++) vec[i] = {4{8'(i * 37 + 11)}};
      for (int i = 0; i < 8; i++) exp_h = lane_add(vec[i], exp_h);
      run_seq(4'd12, -1, 0, 0, 400);
      n_vec++; if (n_st !== 8) begin n_mis++; $display("FAIL len12_starts: got %0d expected 8", n_st); end
      n_vec++; if (n_h !== 8) begin n_mis++; $display("FAIL len12_hcount: got %0d expected 8", n_h); end
      n_vec++; if (ev_h[7] !== exp_h) begin n_mis++; $display("FAIL len12_final: got %h expected %h", ev_h[7], exp_h); end
      n_vec++; if (step_idx !== 4'd7) begin n_mis++; $display("FAIL len12_step: got %0d expected 7", step_idx); end
   endtask

   task automatic test_reset_mid_run();
      seq_start = 1'b1; seq_len = 4'd3;
      @(negedge clk);
      seq_start = 1'b0;
      if (!bus.in_ready) wait_for(0, 20, "ready0");
      bus.in_valid = 1'b1; bus.in_data = X1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      wait_for(1, 60, "h0");
      if (!bus.in_ready) wait_for(0, 20, "ready1");
      bus.in_valid = 1'b1; bus.in_data = X2;
      @(negedge clk);
      bus.in_valid = 1'b0;
      wait_for(3, 20, "run1");
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      n_vec++; if (bus.core_start !== 1'b0) begin n_mis++; $display("FAIL mid_core_start: got 1 expected 0"); end
      n_vec++;
      if ({h_valid, busy, seq_done, timeout_err, bus.in_ready, h_data, bus.core_x, bus.core_y_in, step_idx} !== '0) begin
         n_mis++;
         $display("FAIL mid_outputs: busy %b h %h x %h step %0d expected all 0", busy, h_data, bus.core_x, step_idx);
      end
      stray_fin = 1'b1;
      @(negedge clk);
      stray_fin = 1'b0;
      n_vec++;
      if ({h_valid, busy, h_data} !== '0) begin
         n_mis++; $display("FAIL stray_finish: h_valid %b busy %b h %h expected 0", h_valid, busy, h_data);
      end
      @(negedge clk);
      vec[0] = X2;
      run_seq(4'd1, -1, 0, 0, 200);
      n_vec++; if (ev_cy[0] !== '0) begin n_mis++; $display("FAIL mid_restart_y_in: got %h expected 0", ev_cy[0]); end
      n_vec++;
      if (n_h !== 1 || ev_h[0] !== X2) begin
         n_mis++; $display("FAIL mid_restart_h: count %0d h %h expected 1, %h", n_h, ev_h[0], X2);
      end
   endtask

   initial begin
      test_reset();
      test_single_step();
      test_two_steps();
      test_stall();
      test_timeout();
      test_len_edges();
      test_reset_mid_run();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end
endmodule
